// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
// Inputs: LSU req/done, fetch busy, ID source regs, EX load dest, EX redirect.
// Outputs: per-register stalls, IF/ID and ID/EX flushes, PC redirect, sticky LSU watchdog error.
// Define PIPE_PERF_EN to add the 64-bit perf_* event counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 1024,
  parameter int CNT_W = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_busy,
  input  logic        lsu_req,
  input  logic        lsu_done,
  input  logic        id_rs1_ren,
  input  logic        id_rs2_ren,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_ram_re,
  input  logic [4:0]  ex_reg_waddr,
  input  logic        ex_redirect_valid,
  input  logic [63:0] ex_redirect_pc,
`ifdef PIPE_PERF_EN
  output logic [63:0] perf_mem_stall,
  output logic [63:0] perf_loaduse,
  output logic [63:0] perf_redirect,
  output logic [63:0] perf_fetch_stall,
`endif
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        mem_wb_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        mem_timeout
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIR_PEND} state_t;
  localparam logic [CNT_W-1:0] TO = CNT_W'(MEM_TIMEOUT);
  state_t state_q, state_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic mem_timeout_q, mem_timeout_d;
  logic load_use, freeze, f_ifid, f_idex, rv;
  logic [4:0] stl;
  logic [63:0] rpc;
  assign load_use = ex_ram_re && ex_reg_waddr != 5'd0 &&
                    ((id_rs1_ren && id_rs1 == ex_reg_waddr) || (id_rs2_ren && id_rs2 == ex_reg_waddr));
  assign freeze = lsu_req && !lsu_done;
  // stl bit order: {pc, if_id, id_ex, ex_mem, mem_wb}
  always_comb begin
    state_d = state_q;
    pend_pc_d = pend_pc_q;
    wdog_d = wdog_q;
    mem_timeout_d = mem_timeout_q;
    stl = '0;
    f_ifid = 1'b0;
    f_idex = 1'b0;
    rv = 1'b0;
    rpc = '0;
    case (state_q)
      RUN: begin
        if (freeze) begin
          stl = 5'b11111;
          wdog_d = '0;
          state_d = MEM_WAIT;
        end else if (ex_redirect_valid) begin
          f_ifid = 1'b1;
          f_idex = 1'b1;
          if (ifu_busy) begin
            stl = 5'b10000;
            pend_pc_d = ex_redirect_pc;
            state_d = REDIR_PEND;
          end else begin
            rv = 1'b1;
            rpc = ex_redirect_pc;
          end
        end else if (load_use) begin
          stl = 5'b11100;
        end else if (ifu_busy) begin
          stl = 5'b11000;
        end
      end
      MEM_WAIT: begin
        wdog_d = (wdog_q == TO) ? wdog_q : wdog_q + 1'b1;
        mem_timeout_d = mem_timeout_q | (wdog_q == TO);
        stl = lsu_done ? 5'b00000 : 5'b11111;
        state_d = lsu_done ? RUN : MEM_WAIT;
      end
      REDIR_PEND: begin
        stl = 5'b11000;
        if (!ifu_busy) begin
          rv = 1'b1;
          rpc = pend_pc_q;
          f_ifid = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_pc_q <= '0;
      wdog_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_pc_q <= pend_pc_d;
      wdog_q <= wdog_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
  // Flush beats stall on the same register; everything reads 0 while in reset.
  assign pc_stall = rst_n & stl[4];
  assign if_id_stall = rst_n & stl[3] & ~f_ifid;
  assign id_ex_stall = rst_n & stl[2] & ~f_idex;
  assign ex_mem_stall = rst_n & stl[1];
  assign mem_wb_stall = rst_n & stl[0];
  assign if_id_flush = rst_n & f_ifid;
  assign id_ex_flush = rst_n & f_idex;
  assign redirect_valid = rst_n & rv;
  assign redirect_pc = {64{rst_n}} & rpc;
  assign mem_timeout = rst_n & mem_timeout_q;
`ifdef PIPE_PERF_EN
  logic [63:0] pm_q, pl_q, pr_q, pf_q;
  // In RUN, 11100 only arises from load-use and 11000 only from a bare fetch wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pm_q <= '0;
      pl_q <= '0;
      pr_q <= '0;
      pf_q <= '0;
    end else begin
      pm_q <= pm_q + 64'(&stl);
      pl_q <= pl_q + 64'(state_q == RUN && stl == 5'b11100);
      pr_q <= pr_q + 64'(rv);
      pf_q <= pf_q + 64'(state_q == RUN && stl == 5'b11000);
    end
  end
  assign perf_mem_stall = {64{rst_n}} & pm_q;
  assign perf_loaduse = {64{rst_n}} & pl_q;
  assign perf_redirect = {64{rst_n}} & pr_q;
  assign perf_fetch_stall = {64{rst_n}} & pf_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl with MEM_TIMEOUT=8
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n, ifu_busy, lsu_req, lsu_done, id_rs1_ren, id_rs2_ren, ex_ram_re, ex_redirect_valid;
  logic [4:0] id_rs1, id_rs2, ex_reg_waddr;
  logic [63:0] ex_redirect_pc, redirect_pc;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_flush, id_ex_flush, redirect_valid, mem_timeout;
  int passed = 0;
  int total = 0;
`ifdef PIPE_PERF_EN
  logic [63:0] perf_mem_stall, perf_loaduse, perf_redirect, perf_fetch_stall;
`endif
  pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ifu_busy(ifu_busy), .lsu_req(lsu_req), .lsu_done(lsu_done),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_ram_re(ex_ram_re), .ex_reg_waddr(ex_reg_waddr), .ex_redirect_valid(ex_redirect_valid),
    .ex_redirect_pc(ex_redirect_pc),
`ifdef PIPE_PERF_EN
    .perf_mem_stall(perf_mem_stall), .perf_loaduse(perf_loaduse),
    .perf_redirect(perf_redirect), .perf_fetch_stall(perf_fetch_stall),
`endif
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  wire [4:0] stalls = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall};
  wire [1:0] flushes = {if_id_flush, id_ex_flush};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic idle();
    ifu_busy = 0; lsu_req = 0; lsu_done = 0; id_rs1_ren = 0; id_rs2_ren = 0;
    id_rs1 = 0; id_rs2 = 0; ex_ram_re = 0; ex_reg_waddr = 0;
    ex_redirect_valid = 0; ex_redirect_pc = 0;
  endtask
  task automatic step();
    @(negedge clk);
    idle();
  endtask
  initial begin
    rst_n = 0;
    idle();
    lsu_req = 1; ex_redirect_valid = 1; ex_redirect_pc = 64'h1234; ifu_busy = 1;
    #1;
    chk("rst_ctrl", {59'd0, stalls}, 0);
    chk("rst_misc", {flushes, redirect_valid, mem_timeout}, 0);
    chk("rst_pc", redirect_pc, 0);
    step(); rst_n = 0;
    step(); rst_n = 1;
    #1 chk("idle", {stalls, flushes, redirect_valid, mem_timeout}, 0);
    step(); ex_ram_re = 1; ex_reg_waddr = 5; id_rs1_ren = 1; id_rs1 = 5;
    #1 chk("lu_rs1", stalls, 5'b11100);
    chk("lu_noflush", {flushes, redirect_valid}, 0);
    step(); ex_ram_re = 1; ex_reg_waddr = 0; id_rs1_ren = 1; id_rs1 = 0;
    #1 chk("lu_x0", stalls, 0);
    step(); ex_ram_re = 1; ex_reg_waddr = 7; id_rs2_ren = 1; id_rs2 = 7;
    #1 chk("lu_rs2", stalls, 5'b11100);
    step(); ex_ram_re = 1; ex_reg_waddr = 7; id_rs2_ren = 0; id_rs2 = 7;
    #1 chk("lu_noren", stalls, 0);
    for (int i = 0; i < 3; i++) begin
      step(); lsu_req = 1;
      #1 chk($sformatf("lsu_wait%0d", i), stalls, 5'b11111);
    end
    step(); lsu_req = 1; lsu_done = 1;
    #1 chk("lsu_done", stalls, 0);
    step();
    #1 chk("lsu_back_run", stalls, 0);
    step(); lsu_req = 1; lsu_done = 1;
    #1 chk("lsu_single", stalls, 0);
    step(); ex_redirect_valid = 1; ex_redirect_pc = 64'h80000100;
    ex_ram_re = 1; ex_reg_waddr = 5; id_rs1_ren = 1; id_rs1 = 5;
    #1 chk("redir_v", {flushes, redirect_valid}, 3'b111);
    chk("redir_pc", redirect_pc, 64'h80000100);
    chk("redir_lu_supp", stalls, 0);
    step(); ex_redirect_valid = 1; ex_redirect_pc = 64'h80000200; ifu_busy = 1;
    #1 chk("pend_c0", {stalls, flushes, redirect_valid}, 8'b10000_11_0);
    chk("pend_c0_pc", redirect_pc, 0);
    for (int i = 0; i < 4; i++) begin
      step(); ifu_busy = 1; ex_redirect_valid = (i == 0); ex_redirect_pc = 64'hdead;
      #1 chk($sformatf("pend_wait%0d", i), {stalls, flushes, redirect_valid}, 8'b11000_00_0);
    end
    step();
    #1 chk("pend_out", {flushes, redirect_valid}, 3'b101);
    chk("pend_out_pc", redirect_pc, 64'h80000200);
    step();
    #1 chk("pend_done", {stalls, flushes, redirect_valid}, 0);
    step(); ifu_busy = 1;
    #1 chk("fetch_only", stalls, 5'b11000);
    step(); ifu_busy = 1; ex_ram_re = 1; ex_reg_waddr = 9; id_rs1_ren = 1; id_rs1 = 9;
    #1 chk("fetch_lu", stalls, 5'b11100);
    step(); lsu_req = 1; ex_redirect_valid = 1; ex_redirect_pc = 64'h80000300;
    #1 chk("prio_freeze", {stalls, flushes, redirect_valid}, 8'b11111_00_0);
    for (int n = 1; n <= 12; n++) begin
      step(); lsu_req = 1; ex_redirect_valid = (n == 1); ex_redirect_pc = 64'h80000300;
      #1;
      if (n == 1) chk("mw_redir_ign", {stalls, flushes, redirect_valid}, 8'b11111_00_0);
      if (n == 5) chk("wdog_early", mem_timeout, 0);
      if (n == 12) chk("wdog_fire", {stalls, mem_timeout}, 6'b11111_1);
    end
    step(); lsu_req = 1; lsu_done = 1;
    #1 chk("wdog_done", {stalls, mem_timeout}, 6'b00000_1);
    step();
    #1 chk("wdog_sticky", mem_timeout, 1);
    step(); lsu_req = 1;
    step(); lsu_req = 1; rst_n = 0;
    #1 chk("rst_mw", {stalls, flushes, redirect_valid, mem_timeout}, 0);
    step(); rst_n = 1;
    #1 chk("rst_mw_after", {stalls, redirect_valid, mem_timeout}, 0);
    step(); ex_redirect_valid = 1; ex_redirect_pc = 64'h80000400; ifu_busy = 1;
    #1 chk("rp_enter", pc_stall, 1);
    step(); ifu_busy = 1; rst_n = 0;
    #1 chk("rst_rp", {stalls, flushes, redirect_valid}, 0);
    step(); rst_n = 1;
    #1 chk("rst_rp_after", {stalls, flushes, redirect_valid}, 0);
    chk("rst_rp_pc", redirect_pc, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RV64 pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives the per-register stall controls. Stage register convention: stall=1 with downstream stall=0 loads a bubble; stall=1 with downstream stall=1 holds.
- Sources it arbitrates: multi-cycle LSU accesses, multi-cycle instruction fetch, load-use hazards and EX-stage redirects (branch/jump/trap).
- Holds a redirect that arrives while a fetch is outstanding.
- Runs a watchdog on LSU waits.

Parameters:
MEM_TIMEOUT, 1024, number of MEM_WAIT cycles before mem_timeout is raised.
CNT_W, 11, width of the watchdog counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ifu_busy  in  1  fetch outstanding; IF output not valid this cycle
lsu_req  in  1  EX/MEM instruction performs a load or store this cycle
lsu_done  in  1  LSU access completes this cycle
id_rs1_ren  in  1  ID instruction reads rs1
id_rs2_ren  in  1  ID instruction reads rs2
id_rs1  in  5  ID rs1 index
id_rs2  in  5  ID rs2 index
ex_ram_re  in  1  ID/EX instruction is a load
ex_reg_waddr  in  5  ID/EX destination index
ex_redirect_valid  in  1  EX resolves a taken branch, jump or trap
ex_redirect_pc  in  64  redirect target
pc_stall  out  1  hold PC
if_id_stall  out  1  IF/ID stall
id_ex_stall  out  1  ID/EX stall
ex_mem_stall  out  1  EX/MEM stall
mem_wb_stall  out  1  MEM/WB stall
if_id_flush  out  1  clear IF/ID next edge
id_ex_flush  out  1  clear ID/EX next edge
redirect_valid  out  1  load redirect_pc into PC next edge
redirect_pc  out  64  redirect target
mem_timeout  out  1  sticky watchdog error

Behaviour:
- Registered state: FSM {RUN, MEM_WAIT, REDIR_PEND}, pend_pc[63:0], wdog[CNT_W-1:0], mem_timeout.
- All other outputs are combinational from state and inputs, with zero latency.
- While rst_n=0, every output is 0. On the reset edge: state=RUN, pend_pc=0, wdog=0, mem_timeout=0. Reset mid-wait abandons the wait.
- Load-use hazard: ex_ram_re && ex_reg_waddr!=0 && ((id_rs1_ren && id_rs1==ex_reg_waddr) || (id_rs2_ren && id_rs2==ex_reg_waddr)).
- Priority in RUN: memory freeze > redirect > load-use > fetch wait.
- RUN, lsu_req && !lsu_done: all five stalls = 1; redirect and flush outputs = 0; next state MEM_WAIT; wdog <= 0.
- RUN, lsu_req && lsu_done: single-cycle access, no freeze; lower priorities are evaluated normally.
- MEM_WAIT: all five stalls = 1; ex_redirect_valid is ignored because EX is frozen and it will be re-presented.
  - wdog increments and saturates at MEM_TIMEOUT.
  - When wdog==MEM_TIMEOUT, mem_timeout is set (sticky until reset) and the state remains MEM_WAIT.
- MEM_WAIT, lsu_done: stalls = 0 in the same cycle; next state RUN.
- RUN redirect (ex_redirect_valid, no freeze): if_id_flush=1, id_ex_flush=1; load-use is suppressed.
  - If !ifu_busy: redirect_valid=1, redirect_pc=ex_redirect_pc; stay in RUN.
  - If ifu_busy: pend_pc <= ex_redirect_pc; pc_stall=1; redirect_valid=0; next state REDIR_PEND.
- REDIR_PEND: pc_stall=1, if_id_stall=1 (IF/ID bubble); other stalls 0; new ex_redirect_valid is ignored because the pipe behind it was flushed.
  - On the first cycle with !ifu_busy: redirect_valid=1, redirect_pc=pend_pc, if_id_flush=1 (discards the wrong-path fetch); next state RUN.
- RUN load-use: pc_stall=1, if_id_stall=1, id_ex_stall=1, ex_mem_stall=0, mem_wb_stall=0. The net effect is a bubble into ID/EX while the ID instruction is held, for exactly 1 cycle.
- RUN ifu_busy only: pc_stall=1, if_id_stall=1, the rest 0 (bubble into IF/ID).
- Load-use together with ifu_busy: the load-use encoding is used; pc_stall=1.
- When both a flush and a stall apply to the same register, the flush wins.
- When redirect_valid=0, redirect_pc=0.

Optional Feature:
PIPE_PERF_EN:
- Defined: adds 64-bit output ports perf_mem_stall, perf_loaduse, perf_redirect, perf_fetch_stall. Reset to 0; they wrap at 2^64.
  - perf_mem_stall counts cycles with all stalls asserted.
  - perf_loaduse counts load-use bubbles.
  - perf_redirect counts redirect_valid cycles.
  - perf_fetch_stall counts RUN cycles stalled only by ifu_busy.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_ram_re=1, ex_reg_waddr=5, id_rs1_ren=1, id_rs1=5 for one cycle -> pc/if_id/id_ex stall=1, ex_mem/mem_wb=0. Same with ex_reg_waddr=0 -> no stall.
- LSU wait: lsu_req=1, lsu_done low for 3 cycles then high -> all stalls =1 for 3 cycles, 0 on the done cycle, state RUN. lsu_req=lsu_done=1 in the same cycle -> no stall.
- Redirect: ex_redirect_valid=1, ex_redirect_pc=0x80000100, ifu_busy=0 -> same cycle redirect_valid=1, pc=0x80000100, both flushes=1.
- Pending redirect: redirect to 0x80000200 while ifu_busy=1 for 4 more cycles -> flushes in cycle 0, pc_stall held; on the first cycle with ifu_busy=0, redirect_valid=1, redirect_pc=0x80000200, if_id_flush=1.
- Priority/watchdog (MEM_TIMEOUT=8):
  - Redirect together with lsu_req && !lsu_done -> freeze only, redirect_valid=0.
  - lsu_done held low -> mem_timeout=1 after 8 MEM_WAIT cycles and remains set after lsu_done; clears only on rst_n=0.
- Reset mid-op: rst_n=0 in MEM_WAIT and in REDIR_PEND -> all outputs 0; after release, state RUN and pend_pc discarded.
